// File: rtl/frac_clkgen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// in the refclk domain, producing overflow strobes, square waves and lock flags.
module frac_clkgen #(
  parameter int NUM_CH = 2,
  parameter int ACC_W = 32,
  parameter int LOCK_CYCLES = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(1055531163),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  logic             accept;
  logic             apply;
  logic [CH_W-1:0]  apply_ch;
  logic [ACC_W-1:0] apply_inc;
  logic             apply_en;

  assign accept = cfg_valid && cfg_ready;

  // An accepted request is held for one cycle and applied on the next edge,
  // which is why ready is low during that apply cycle.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      cfg_ready <= 1'b0;
      apply     <= 1'b0;
      apply_ch  <= '0;
      apply_inc <= '0;
      apply_en  <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      apply     <= accept;
      if (accept) begin
        apply_ch  <= cfg_ch;
        apply_inc <= cfg_inc;
        apply_en  <= cfg_en;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, inc_q;
    logic [ACC_W:0]   sum;
    logic             en_q, ce_q, clk_q;
    logic             hit, start;

    // Out-of-range channel numbers never match, so such requests change nothing.
    assign hit   = apply && (apply_ch == CH_W'(i));
    assign start = apply_en && (apply_inc != '0);
    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (hit) begin
        state_d = start ? SETTLE : IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          SETTLE: begin
            if (cnt_q == CNT_LAST) state_d = LOCKED;
            else                   cnt_d   = cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
        state_q <= SETTLE;
        cnt_q   <= '0;
        acc_q   <= '0;
        inc_q   <= DEFAULT_INC;
        en_q    <= 1'b1;
        ce_q    <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (hit) begin
          inc_q <= apply_inc;
          en_q  <= apply_en;
          acc_q <= '0;
          ce_q  <= 1'b0;
          clk_q <= 1'b0;
        end else if (en_q && state_q != IDLE) begin
          acc_q <= sum[ACC_W-1:0];
          ce_q  <= sum[ACC_W];
          clk_q <= sum[ACC_W-1];
        end else begin
          acc_q <= '0;
          ce_q  <= 1'b0;
          clk_q <= 1'b0;
        end
      end
    end

    assign ce[i]      = ce_q;
    assign clk_out[i] = clk_q;
    assign locked[i]  = (state_q == LOCKED);
  end

endmodule

// File: tb/tb_frac_clkgen.sv
// Directed bench for frac_clkgen: vector table of channel configurations plus
// hand-written reset, handshake, isolation and mid-settle reset sequences.
module tb_frac_clkgen;

  localparam int NUM_CH = 3;
  localparam int ACC_W = 32;
  localparam int LOCK_CYCLES = 16;

  logic        refclk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_ch = '0;
  logic [31:0] cfg_inc = '0;
  logic        cfg_en = 1'b0;
  logic [2:0]  ce, clk_out, locked;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int mon_last = -1;
  int ce_cnt [3];

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] inc;
    logic        en;
    int          first_ce;
    int          ce_total;
    int          high_total;
    logic        lock16;
  } vec_t;

  vec_t vecs [9];

  frac_clkgen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES),
    .DEFAULT_INC(32'd1055531163)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_en(cfg_en),
    .ce(ce), .clk_out(clk_out), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every wait goes through here so the ch1 watcher sees each cycle.
  task automatic tick();
    @(negedge refclk);
    cyc++;
    if (mon_en) begin
      checkOutput("ch1_locked_held", 64'(locked[1]), 64'd1);
      if (ce[1]) begin
        if (mon_last >= 0) checkOutput("ch1_ce_gap", 64'(cyc - mon_last), 64'd4);
        mon_last = cyc;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] inc, input logic en);
    int waited = 0;
    while (!cfg_ready && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput("ready_before_req", 64'(cfg_ready), 64'd1);
    cfg_ch = ch;
    cfg_inc = inc;
    cfg_en = en;
    cfg_valid = 1'b1;
    tick();
    checkOutput("ready_apply_cycle", 64'(cfg_ready), 64'd0);
    cfg_valid = 1'b0;
    tick();
    checkOutput("ready_after_apply", 64'(cfg_ready), 64'd1);
  endtask

  // Defaults: inc/2^32 = 0.24576, so MSB first set after E3, first carry at E5.
  task automatic runAfterReset(input int n);
    for (int c = 0; c < 3; c++) ce_cnt[c] = 0;
    for (int e = 1; e <= n; e++) begin
      tick();
      if (e == 1)  checkOutput("e1_ready", 64'(cfg_ready), 64'd1);
      if (e == 2)  checkOutput("e2_clk_out", 64'(clk_out), 64'd0);
      if (e == 3)  checkOutput("e3_clk_out", 64'(clk_out), 64'd7);
      if (e == 4)  checkOutput("e4_ce", 64'(ce), 64'd0);
      if (e == 5)  checkOutput("e5_ce", 64'(ce), 64'd7);
      if (e == 15) checkOutput("e15_locked", 64'(locked), 64'd0);
      if (e == 16) checkOutput("e16_locked", 64'(locked), 64'd7);
      for (int c = 0; c < 3; c++) ce_cnt[c] += int'(ce[c]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first, nce, nhigh, zero_hits;
    logic [3:0]  held_ready;
    logic [1:0]  held_ch [4];
    logic [31:0] held_inc [4];

    vecs[0] = '{2'd0, 32'h4000_0000, 1'b1,  4,  6, 12, 1'b1};
    vecs[1] = '{2'd0, 32'h8000_0000, 1'b1,  2, 12, 12, 1'b1};
    vecs[2] = '{2'd1, 32'h2000_0000, 1'b1,  8,  3, 12, 1'b1};
    vecs[3] = '{2'd2, 32'hC000_0000, 1'b1,  2, 18, 12, 1'b1};
    vecs[4] = '{2'd0, 32'h3000_0000, 1'b1,  6,  4, 12, 1'b1};
    vecs[5] = '{2'd0, 32'h3000_0000, 1'b1,  6,  4, 12, 1'b1};
    vecs[6] = '{2'd1, 32'hFFFF_FFFF, 1'b1,  2, 23, 24, 1'b1};
    vecs[7] = '{2'd2, 32'h0000_0000, 1'b1, -1,  0,  0, 1'b0};
    vecs[8] = '{2'd0, 32'h4000_0000, 1'b0, -1,  0,  0, 1'b0};

    // Reset state, then long-run default rate: floor(50000*inc/2^32) = 12288.
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    checkOutput("rst_ce", 64'(ce), 64'd0);
    checkOutput("rst_clk_out", 64'(clk_out), 64'd0);
    checkOutput("rst_locked", 64'(locked), 64'd0);
    checkOutput("rst_ready", 64'(cfg_ready), 64'd0);
    rst = 1'b1;
    runAfterReset(50000);
    for (int c = 0; c < 3; c++)
      checkOutput($sformatf("ce_count_ch%0d", c), 64'(ce_cnt[c]), 64'd12288);

    // Vector table: observe 24 cycles after each apply edge.
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].ch, vecs[v].inc, vecs[v].en);
      checkOutput($sformatf("v%0d_ce_apply", v), 64'(ce[vecs[v].ch]), 64'd0);
      checkOutput($sformatf("v%0d_clk_apply", v), 64'(clk_out[vecs[v].ch]), 64'd0);
      checkOutput($sformatf("v%0d_lock_apply", v), 64'(locked[vecs[v].ch]), 64'd0);
      first = -1;
      nce = 0;
      nhigh = 0;
      for (int k = 1; k <= 24; k++) begin
        tick();
        if (ce[vecs[v].ch]) begin
          nce++;
          if (first < 0) first = k;
        end
        if (clk_out[vecs[v].ch]) nhigh++;
        if (k == 15) checkOutput($sformatf("v%0d_lock15", v), 64'(locked[vecs[v].ch]), 64'd0);
        if (k == 16) checkOutput($sformatf("v%0d_lock16", v), 64'(locked[vecs[v].ch]), 64'(vecs[v].lock16));
      end
      checkOutput($sformatf("v%0d_first_ce", v), 64'(first), 64'(vecs[v].first_ce));
      checkOutput($sformatf("v%0d_ce_total", v), 64'(nce), 64'(vecs[v].ce_total));
      checkOutput($sformatf("v%0d_high_total", v), 64'(nhigh), 64'(vecs[v].high_total));
    end

    // ch1 keeps its phase and lock while ch0 is started then disabled.
    applyStimulus(2'd1, 32'h4000_0000, 1'b1);
    repeat (20) tick();
    mon_last = -1;
    mon_en = 1'b1;
    applyStimulus(2'd0, 32'h8000_0000, 1'b1);
    repeat (6) tick();
    applyStimulus(2'd0, 32'h8000_0000, 1'b0);
    checkOutput("off_ce0", 64'(ce[0]), 64'd0);
    checkOutput("off_clk0", 64'(clk_out[0]), 64'd0);
    checkOutput("off_lock0", 64'(locked[0]), 64'd0);
    zero_hits = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ce[0] || clk_out[0] || locked[0]) zero_hits++;
    end
    checkOutput("off_ch0_quiet", 64'(zero_hits), 64'd0);

    // Out-of-range channel: handshake completes, nothing changes.
    applyStimulus(2'd3, 32'h0000_0000, 1'b0);
    for (int k = 0; k < 12; k++) begin
      checkOutput("badch_locked", 64'(locked), 64'd2);
      tick();
    end
    mon_en = 1'b0;

    // Valid held for four cycles: only the 1st and 3rd requests transfer.
    held_ready = 4'b0101;
    held_ch = '{2'd0, 2'd1, 2'd1, 2'd0};
    held_inc = '{32'h8000_0000, 32'h1111_1111, 32'h2000_0000, 32'h5555_5555};
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("held_ready%0d", c), 64'(cfg_ready), 64'(held_ready[c]));
      cfg_ch = held_ch[c];
      cfg_inc = held_inc[c];
      cfg_en = 1'b1;
      cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    checkOutput("held_ce0_j0", 64'(ce[0]), 64'd1);
    checkOutput("held_ce1_j0", 64'(ce[1]), 64'd0);
    checkOutput("held_lock_j0", 64'(locked[1:0]), 64'd0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j == 1)  checkOutput("held_ce0_j1", 64'(ce[0]), 64'd0);
      if (j == 7)  checkOutput("held_ce1_j7", 64'(ce[1]), 64'd0);
      if (j == 8)  checkOutput("held_ce1_j8", 64'(ce[1]), 64'd1);
      if (j == 13) checkOutput("held_lock0_j13", 64'(locked[0]), 64'd0);
      if (j == 14) checkOutput("held_lock0_j14", 64'(locked[0]), 64'd1);
      if (j == 15) checkOutput("held_lock1_j15", 64'(locked[1]), 64'd0);
      if (j == 16) checkOutput("held_lock1_j16", 64'(locked[1]), 64'd1);
    end

    // Asynchronous reset three edges after an accept, mid-settle.
    applyStimulus(2'd0, 32'h4000_0000, 1'b1);
    tick();
    @(posedge refclk);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_ce", 64'(ce), 64'd0);
    checkOutput("arst_clk_out", 64'(clk_out), 64'd0);
    checkOutput("arst_locked", 64'(locked), 64'd0);
    checkOutput("arst_ready", 64'(cfg_ready), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    runAfterReset(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
